// File: rtl/y86_pkg.sv
// Shared Y86-64 constants and the forwarding-source encoding used by the
// decode-stage operand selectors.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE   = 4'hF;

  typedef enum logic [2:0] {
    FWD_RF   = 3'd0,
    FWD_VALP = 3'd1,
    FWD_E    = 3'd2,
    FWD_MM   = 3'd3,
    FWD_ME   = 3'd4,
    FWD_WM   = 3'd5,
    FWD_WE   = 3'd6
  } fwd_src_e;

endpackage

// File: rtl/fwd_prio_mux.sv
// Generic priority matcher: the first dst equal to src (index 0 is youngest)
// supplies the value; idx_o is the 1-based hit position, or 0 for the default.
module fwd_prio_mux #(
  parameter int         W     = 64,
  parameter int         N     = 5,
  parameter int         IW    = $clog2(N + 1),
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic [3:0]   src_i,
  input  logic [3:0]   dst_i  [N],
  input  logic [W-1:0] val_i  [N],
  input  logic [W-1:0] dflt_i,
  output logic [W-1:0] val_o,
  output logic [IW-1:0] idx_o
);

  // Walk from oldest to youngest so the lowest matching index ends up winning.
  always_comb begin
    val_o = dflt_i;
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if ((src_i != RNONE) && (src_i == dst_i[k])) begin
        val_o = val_i[k];
        idx_o = IW'(k + 1);
      end
    end
  end

endmodule

// File: rtl/fwd_sel.sv
// Decode-stage A-operand forwarding selector: valP override for CALL/JXX,
// otherwise youngest in-flight match, otherwise the register-file read.
module fwd_sel #(
  parameter int         W     = 64,
  parameter logic [3:0] RNONE = y86_pkg::RNONE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   D_icode,
  input  logic [W-1:0] D_valP,
  input  logic [3:0]   d_srcA,
  input  logic [W-1:0] d_rvalA,
  input  logic [3:0]   e_dstE,
  input  logic [W-1:0] e_valE,
  input  logic [3:0]   M_dstM,
  input  logic [W-1:0] m_valM,
  input  logic [3:0]   M_dstE,
  input  logic [W-1:0] M_valE,
  input  logic [3:0]   W_dstM,
  input  logic [W-1:0] W_valM,
  input  logic [3:0]   W_dstE,
  input  logic [W-1:0] W_valE,
  output logic [W-1:0] d_valA,
  output logic [2:0]   fwdA_src_q
);
  import y86_pkg::*;

  localparam int NFWD = 5;
  localparam int IW   = 3;

  logic [3:0]    dst_a [NFWD];
  logic [W-1:0]  val_a [NFWD];
  logic [W-1:0]  mux_val;
  logic [IW-1:0] mux_idx;
  fwd_src_e      fwd_src_d;

  // Pair order sets priority: E, M(mem), M(alu), W(mem), W(alu).
  assign dst_a[0] = e_dstE;  assign val_a[0] = e_valE;
  assign dst_a[1] = M_dstM;  assign val_a[1] = m_valM;
  assign dst_a[2] = M_dstE;  assign val_a[2] = M_valE;
  assign dst_a[3] = W_dstM;  assign val_a[3] = W_valM;
  assign dst_a[4] = W_dstE;  assign val_a[4] = W_valE;

  fwd_prio_mux #(
    .W     (W),
    .N     (NFWD),
    .IW    (IW),
    .RNONE (RNONE)
  ) u_prio (
    .src_i  (d_srcA),
    .dst_i  (dst_a),
    .val_i  (val_a),
    .dflt_i (d_rvalA),
    .val_o  (mux_val),
    .idx_o  (mux_idx)
  );

  always_comb begin
    d_valA    = mux_val;
    fwd_src_d = FWD_RF;
    if ((D_icode == ICALL) || (D_icode == IJXX)) begin
      d_valA    = D_valP;
      fwd_src_d = FWD_VALP;
    end else if (mux_idx != '0) begin
      fwd_src_d = fwd_src_e'(mux_idx + 3'd1);
    end
  end

  // Monitor register: source code of the operand chosen in the previous cycle.
  always_ff @(posedge clk) begin
    if (rst) fwdA_src_q <= FWD_RF;
    else     fwdA_src_q <= fwd_src_d;
  end

endmodule

// File: tb/tb_fwd_sel.sv
// Self-checking bench for fwd_sel: directed hazard cases plus randomized
// traffic compared against a behavioural forwarding model.
module tb_fwd_sel;

  logic        clk;
  logic        rst;
  logic [3:0]  D_icode;
  logic [63:0] D_valP;
  logic [3:0]  d_srcA;
  logic [63:0] d_rvalA;
  logic [3:0]  e_dstE;
  logic [63:0] e_valE;
  logic [3:0]  M_dstM;
  logic [63:0] m_valM;
  logic [3:0]  M_dstE;
  logic [63:0] M_valE;
  logic [3:0]  W_dstM;
  logic [63:0] W_valM;
  logic [3:0]  W_dstE;
  logic [63:0] W_valE;
  logic [63:0] d_valA;
  logic [2:0]  fwdA_src_q;

  int checks = 0;
  int errors = 0;

  fwd_sel #(.W(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .D_icode    (D_icode),
    .D_valP     (D_valP),
    .d_srcA     (d_srcA),
    .d_rvalA    (d_rvalA),
    .e_dstE     (e_dstE),
    .e_valE     (e_valE),
    .M_dstM     (M_dstM),
    .m_valM     (m_valM),
    .M_dstE     (M_dstE),
    .M_valE     (M_valE),
    .W_dstM     (W_dstM),
    .W_valM     (W_valM),
    .W_dstE     (W_dstE),
    .W_valE     (W_valE),
    .d_valA     (d_valA),
    .fwdA_src_q (fwdA_src_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: a CALL/JXX takes valP; otherwise collect every stage holding
  // the wanted register and keep the youngest one (smallest stage code).
  task automatic model(output logic [63:0] v, output logic [2:0] c);
    logic [3:0]  ids  [5];
    logic [63:0] vals [5];
    int best;
    ids  = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    vals = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    if (D_icode == 4'h8 || D_icode == 4'h7) begin
      v = D_valP;
      c = 3'd1;
    end else begin
      best = 7;
      v = d_rvalA;
      c = 3'd0;
      if (d_srcA != 4'hF) begin
        for (int s = 4; s >= 0; s--)
          if (ids[s] == d_srcA && (s + 2) < best) best = s + 2;
      end
      if (best < 7) begin
        v = vals[best - 2];
        c = 3'(best);
      end
    end
  endtask

  // Check the combinational operand now, then the registered code after the edge.
  task automatic step(input string tag, input logic [63:0] ev, input logic [2:0] ec);
    #1;
    chk({tag, "_val"}, d_valA, ev);
    @(posedge clk);
    #1;
    chk({tag, "_code"}, {61'd0, fwdA_src_q}, {61'd0, ec});
  endtask

  task automatic idle_inputs();
    D_icode = 4'h2;  D_valP = 64'h1000;
    d_srcA  = 4'h3;  d_rvalA = 64'hAAAA;
    e_dstE  = 4'h5;  e_valE = 64'h11;
    M_dstM  = 4'hC;  m_valM = 64'h22;
    M_dstE  = 4'hF;  M_valE = 64'h33;
    W_dstM  = 4'h5;  W_valM = 64'h44;
    W_dstE  = 4'hC;  W_valE = 64'h55;
  endtask

  function automatic logic [3:0] pick_id();
    logic [3:0] tbl [4];
    tbl = '{4'h1, 4'h2, 4'h3, 4'hF};
    return tbl[$urandom_range(0, 3)];
  endfunction

  initial begin
    logic [63:0] ev;
    logic [2:0]  ec;

    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_code", {61'd0, fwdA_src_q}, 64'd0);
    rst = 1'b0;

    // valP bypass beats matching W-stage registers
    idle_inputs();
    D_icode = 4'h8; D_valP = 64'd125; d_srcA = 4'h7; W_dstE = 4'h7; W_dstM = 4'h7;
    step("call_valp", 64'd125, 3'd1);
    D_icode = 4'h7; D_valP = 64'hDEAD_BEEF_0000_0001;
    step("jxx_valp", 64'hDEAD_BEEF_0000_0001, 3'd1);

    // W stage: memory value beats ALU value
    idle_inputs();
    d_srcA = 4'h7; W_dstM = 4'h7; W_valM = 64'd30; W_dstE = 4'h7; W_valE = 64'd14;
    step("w_mem", 64'd30, 3'd5);
    W_dstM = 4'hF;
    step("w_alu", 64'd14, 3'd6);

    // Execute beats memory stage
    idle_inputs();
    d_srcA = 4'h4; e_dstE = 4'h4; e_valE = 64'd7; M_dstM = 4'h4; m_valM = 64'd2;
    M_dstE = 4'h4; M_valE = 64'd9;
    step("e_first", 64'd7, 3'd2);
    e_dstE = 4'hF;
    step("m_mem", 64'd2, 3'd3);

    // No match falls through to the register file
    idle_inputs();
    d_srcA = 4'h3; e_dstE = 4'h5; M_dstM = 4'hC; M_dstE = 4'hF; W_dstM = 4'h5; W_dstE = 4'hC;
    d_rvalA = 64'd22;
    step("no_match", 64'd22, 3'd0);

    // RNONE never matches, even against an RNONE destination
    idle_inputs();
    d_srcA = 4'hF; e_dstE = 4'hF; e_valE = 64'd99; d_rvalA = 64'd0;
    step("rnone", 64'd0, 3'd0);

    // Reset clears only the code register; the operand stays forwarded
    idle_inputs();
    d_srcA = 4'h6; M_dstE = 4'h6; M_valE = 64'hFFFF_FFFF_FFFF_FFFE;
    rst = 1'b1;
    step("rst_hold", 64'hFFFF_FFFF_FFFF_FFFE, 3'd0);
    rst = 1'b0;
    step("rst_rel", 64'hFFFF_FFFF_FFFF_FFFE, 3'd4);

    // Randomized traffic with a small ID pool so hazards are frequent
    for (int n = 0; n < 400; n++) begin
      D_icode = 4'($urandom_range(0, 11));
      D_valP  = {$urandom, $urandom};
      d_srcA  = pick_id();
      d_rvalA = {$urandom, $urandom};
      e_dstE  = pick_id();  e_valE = {$urandom, $urandom};
      M_dstM  = pick_id();  m_valM = {$urandom, $urandom};
      M_dstE  = pick_id();  M_valE = {$urandom, $urandom};
      W_dstM  = pick_id();  W_valM = {$urandom, $urandom};
      W_dstE  = pick_id();  W_valE = {$urandom, $urandom};
      model(ev, ec);
      step("rand", ev, ec);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
